// File: rtl/bsg_clkgate_en_ctrl_pkg.sv
// Shared types and sizing helpers for the clock-gate enable controller.
package bsg_clkgate_en_ctrl_pkg;

  typedef enum logic [1:0] {
    eOn   = 2'd0,
    eOff  = 2'd1,
    eWake = 2'd2
  } bsg_clkgate_state_e;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int ctr_width_f(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bsg_clkgate_en_ctrl_if.sv
// Activity requests in, gate controls and statistics out.
interface bsg_clkgate_en_ctrl_if #(
  parameter int num_req_p   = 4,
  parameter int cnt_width_p = 32
);

  logic [num_req_p-1:0]   req_i;
  logic                   gate_allow_i;
  logic                   force_on_i;
  logic                   clear_cnt_i;
  logic                   en_o;
  logic                   bypass_o;
  logic                   ready_o;
  logic [cnt_width_p-1:0] gated_cnt_o;

  modport master (
    output req_i, gate_allow_i, force_on_i, clear_cnt_i,
    input  en_o, bypass_o, ready_o, gated_cnt_o
  );

  modport slave (
    input  req_i, gate_allow_i, force_on_i, clear_cnt_i,
    output en_o, bypass_o, ready_o, gated_cnt_o
  );

endinterface

// File: rtl/bsg_counter_sat_clear_up.sv
// Up-counter that sticks at all-ones; a clear beats a same-cycle increment.
module bsg_counter_sat_clear_up #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (up_i && (count_q != '1)) begin
      count_d = count_q + width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_clkgate_en_ctrl.sv
// Idle-timeout / wake-latency control for a latch+AND clock gate.
// Every output is a flop so the gate cell never sees a combinational hazard.
module bsg_clkgate_en_ctrl
  import bsg_clkgate_en_ctrl_pkg::*;
#(
  parameter int num_req_p     = 4,
  parameter int idle_cycles_p = 8,
  parameter int wake_cycles_p = 2,
  parameter int cnt_width_p   = 32
) (
  input logic                  clk_i,
  input logic                  reset_i,
  bsg_clkgate_en_ctrl_if.slave ctrl_if
);

  localparam int idle_w_lp = ctr_width_f(idle_cycles_p);
  localparam int wake_w_lp = ctr_width_f(wake_cycles_p);
  localparam logic [idle_w_lp-1:0] idle_last_lp = idle_w_lp'(idle_cycles_p - 1);
  localparam logic [wake_w_lp-1:0] wake_last_lp = wake_w_lp'(wake_cycles_p - 1);

  bsg_clkgate_state_e   state_q, state_d;
  logic [idle_w_lp-1:0] idle_cnt_q, idle_cnt_d;
  logic [wake_w_lp-1:0] wake_cnt_q, wake_cnt_d;
  logic                 en_q, en_d;
  logic                 ready_q, ready_d;
  logic                 bypass_q, bypass_d;
  logic                 act;

  // Disallowing gating is treated as permanent activity.
  assign act = (|ctrl_if.req_i) | ctrl_if.force_on_i | ~ctrl_if.gate_allow_i;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    unique case (state_q)
      eOn: begin
        if (act) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == idle_last_lp) begin
          state_d    = eOff;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + idle_w_lp'(1);
        end
      end
      eOff: begin
        if (act) begin
          state_d    = eWake;
          wake_cnt_d = '0;
        end
      end
      eWake: begin
        // A wake always runs to completion, even if activity vanishes.
        if (wake_cnt_q == wake_last_lp) begin
          state_d    = eOn;
          idle_cnt_d = '0;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + wake_w_lp'(1);
        end
      end
      default: begin
        state_d    = eOn;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase

    en_d     = (state_d != eOff);
    ready_d  = (state_d == eOn);
    bypass_d = ctrl_if.force_on_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= eOn;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      en_q       <= 1'b1;
      ready_q    <= 1'b1;
      bypass_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      en_q       <= en_d;
      ready_q    <= ready_d;
      bypass_q   <= bypass_d;
    end
  end

  bsg_counter_sat_clear_up #(
    .width_p (cnt_width_p)
  ) gated_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (ctrl_if.clear_cnt_i),
    .up_i    (~en_q),
    .count_o (ctrl_if.gated_cnt_o)
  );

  assign ctrl_if.en_o     = en_q;
  assign ctrl_if.ready_o  = ready_q;
  assign ctrl_if.bypass_o = bypass_q;

`ifndef SYNTHESIS
  param_range_a: assert property (@(posedge clk_i) (idle_cycles_p >= 1) && (wake_cycles_p >= 1));
  no_x_out_a: assert property (@(posedge clk_i) disable iff (reset_i) !$isunknown({en_q, bypass_q}));
`endif

endmodule

// File: doc/bsg_clkgate_en_ctrl.md
Name: bsg_clkgate_en_ctrl

Overview:
- Upstream control stage for a latch-plus-AND integrated clock gate.
- Watches per-client activity requests and deasserts the gate enable after a programmable idle window.
- Re-enables the clock on demand. Signals readiness only after a fixed wake latency.
- Produces a registered, glitch-free bypass and a saturating gated-cycle statistic.
- All outputs are registered (Moore), so the gate's enable and bypass inputs never see combinational hazards.

Parameters:
- num_req_p, 4: number of client activity request lines.
- idle_cycles_p, 8: consecutive idle cycles in eOn before gating. Must be >= 1.
- wake_cycles_p, 2: cycles the clock runs in eWake before ready_o asserts. Must be >= 1.
- cnt_width_p, 32: width of the gated-cycle counter.

Ports:
- clk_i  in  1  ungated clock; same clock that feeds the gate cell.
- reset_i  in  1  synchronous, active-high reset.
- req_i  in  num_req_p  per-client level activity request; any bit high means active.
- gate_allow_i  in  1  0 = gating disabled; treated as permanent activity.
- force_on_i  in  1  software clock force; registered to bypass_o and also counts as activity.
- clear_cnt_i  in  1  synchronous clear of gated_cnt_o.
- en_o  out  1  registered enable to the clock gate.
- bypass_o  out  1  registered bypass to the clock gate.
- ready_o  out  1  gated domain is clocked and stable; clients may issue work.
- gated_cnt_o  out  cnt_width_p  number of cycles with en_o==0, saturating.

Behaviour:
- Activity definition: act = (|req_i) | force_on_i | ~gate_allow_i.
- States: eOn, eOff, eWake (enum in package). State, idle_cnt, wake_cnt and all outputs are flops.
- Reset (sync, active-high, takes effect at the next edge):
  - state=eOn, idle_cnt=0, wake_cnt=0.
  - en_o=1, ready_o=1, bypass_o=0, gated_cnt_o=0.
  - The clock runs after reset so downstream logic can reset.
- Output decode:
  - en_o = (state != eOff).
  - ready_o = (state == eOn).
  - bypass_o = force_on_i delayed exactly 1 cycle.
- eOn:
  - If act: idle_cnt←0 and stay.
  - Else if idle_cnt == idle_cycles_p-1: state←eOff, idle_cnt←0.
  - Else idle_cnt←idle_cnt+1.
  - Result: en_o falls exactly idle_cycles_p cycles after the first idle cycle. Any act pulse restarts the window.
- eOff:
  - If act: state←eWake, wake_cnt←0. en_o rises on the next cycle.
  - Else stay.
- eWake:
  - wake_cnt increments every cycle.
  - When wake_cnt == wake_cycles_p-1: state←eOn, idle_cnt←0.
  - act dropping during eWake does not abort the wake. The sequence completes to eOn and the idle window then starts fresh.
- Latency: act first sampled high in eOff at cycle w → en_o=1 at w+1 → ready_o=1 at w+1+wake_cycles_p.
- Simultaneous events:
  - act on the same cycle idle_cnt hits its limit: act wins and the state stays eOn.
  - clear_cnt_i together with an increment: clear wins, gated_cnt_o←0.
- gated_cnt_o:
  - Increments each cycle en_o==0.
  - Holds at all-ones; no wrap.
- Reset mid-operation (eOff or eWake): next cycle is eOn with en_o=1 and ready_o=1; counters are zeroed.
- force_on_i high in eOff:
  - bypass_o=1 one cycle later, so the clock runs via bypass.
  - The FSM still executes a normal wake, so ready_o rises wake_cycles_p+1 cycles after force.
- Assertions (non-synthesis):
  - idle_cycles_p >= 1 and wake_cycles_p >= 1.
  - No X on en_o or bypass_o after reset.

Decomposition:
- Package bsg_clkgate_en_ctrl_pkg:
  - state enum bsg_clkgate_state_e {eOn, eOff, eWake}, 2 bits.
  - Helper width localparams: idle counter $clog2(idle_cycles_p+1), wake counter $clog2(wake_cycles_p+1).
- Sub-module: a saturating clear-priority up-counter, bsg_counter_sat_clear_up. It is used for gated_cnt_o.
- idle_cnt and wake_cnt are small inline counters in the FSM.

Test Plan:
- Idle gating:
  - Stimulus: idle_cycles_p=4, reset, req_i=0 from cycle 0.
  - Expected: en_o=1 on cycles 0-3, en_o=0 from cycle 4; ready_o falls with en_o; gated_cnt_o counts 1,2,3… from cycle 5.
- Wake latency:
  - Stimulus: wake_cycles_p=2, in eOff pulse req_i[2]=1 for one cycle at cycle w.
  - Expected: en_o=1 at w+1; ready_o=1 at w+3; with no further requests, en_o falls again at w+3+idle_cycles_p.
- Idle restart and act-wins:
  - Stimulus: in eOn, idle for 3 of 4 cycles, then req_i=1 on the limit cycle.
  - Expected: no gating; the next gating occurs 4 full cycles after req drops.
- Force and bypass:
  - Stimulus: in eOff, force_on_i=1 at cycle f.
  - Expected: bypass_o=1 at f+1; en_o=1 at f+1; ready_o=1 at f+1+wake_cycles_p; no gating while force_on_i=1.
- Counter saturate/clear:
  - Stimulus: cnt_width_p=3, stay gated 10 cycles, then clear_cnt_i=1 on a gated cycle.
  - Expected: gated_cnt_o holds at 7, then reads 0 the next cycle, then resumes at 1.
- Reset mid-wake:
  - Stimulus: reset_i=1 during eWake.
  - Expected: next cycle en_o=1, ready_o=1, gated_cnt_o=0; gate_allow_i=0 afterwards keeps en_o=1 indefinitely.
